// File: rtl/sample_framer_pkg.sv
// Shared definitions for the sample framer.
//   state_t        : framer FSM states
//   CRC8_POLY      : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   DEFAULT_HEADER : default frame start byte
//   crc8_byte()    : advances a CRC-8 by one byte, MSB first, no reflection
package sample_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        DHI,
        DLO,
        CRC
    } state_t;

    localparam logic [7:0] CRC8_POLY      = 8'h07;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sample_framer_fifo.sv
// Synchronous sample FIFO (first-word fall-through head).
//   clk, rst : clock and asynchronous active-high reset
//   push, din: write request and data; ignored while full
//   pop      : removes the head entry; ignored while empty
//   head     : current oldest entry
//   level    : occupancy, 0..DEPTH
//   full     : level == DEPTH
module sample_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level_q != '0);
    assign head    = mem[rd_ptr_q];
    assign level   = level_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sample_framer.sv
// Packs FRAME_SAMPLES fixed-point samples into byte frames:
//   HEADER, seq, {sample[15:8], sample[7:0]} x FRAME_SAMPLES, CRC-8
// The CRC covers seq and data bytes only.
//   clk, reset          : clock and asynchronous active-high reset
//   sample_valid, sample: incoming sample strobe and data
//   tx_data, tx_valid   : outgoing byte stream, accepted when tx_ready is high
//   frame_done          : high in the cycle the CRC byte is accepted
//   overflow            : sticky, a sample arrived while the FIFO was full
//   fifo_level          : current FIFO occupancy
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter  int         FRAME_SAMPLES = 8,
    parameter  int         FIFO_DEPTH    = 16,
    parameter  logic [7:0] HEADER        = DEFAULT_HEADER,
    localparam int         LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [15:0]   sample,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          frame_done,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);

    state_t      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  crc_q, crc_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic        overflow_q;
    logic        fifo_pop;
    logic        fifo_full;
    logic [15:0] fifo_head;

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (sample_valid),
        .din   (sample),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full)
    );

    assign overflow = overflow_q;

    // tx_data is decoded from registered state and the FIFO head, which only
    // moves on a pop, so it stays put while the downstream stalls.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_level >= LW'(FRAME_SAMPLES)) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    crc_d   = 8'h00;
                    cnt_d   = '0;
                    state_d = SEQ;
                end
            end
            SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq_q;
                if (tx_ready) begin
                    crc_d   = crc8_byte(crc_q, seq_q);
                    state_d = DHI;
                end
            end
            DHI: begin
                tx_valid = 1'b1;
                tx_data  = fifo_head[15:8];
                if (tx_ready) begin
                    crc_d   = crc8_byte(crc_q, fifo_head[15:8]);
                    state_d = DLO;
                end
            end
            DLO: begin
                tx_valid = 1'b1;
                tx_data  = fifo_head[7:0];
                if (tx_ready) begin
                    crc_d    = crc8_byte(crc_q, fifo_head[7:0]);
                    fifo_pop = 1'b1;
                    if (cnt_q == LW'(FRAME_SAMPLES - 1)) begin
                        state_d = CRC;
                    end else begin
                        cnt_d   = cnt_q + LW'(1);
                        state_d = DHI;
                    end
                end
            end
            CRC: begin
                tx_valid = 1'b1;
                tx_data  = crc_q;
                if (tx_ready) begin
                    frame_done = 1'b1;
                    seq_d      = seq_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            seq_q      <= 8'h00;
            crc_q      <= 8'h00;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            // A write at full is dropped even if a pop frees space this cycle.
            if (sample_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
